// File: rtl/int_req_pkg.sv
// ============================================================================
// Module      : int_req_pkg
// Description : Shared constants and helpers for the interrupt request array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package int_req_pkg;

    localparam logic TRIG_LEVEL = 1'b1;
    localparam logic TRIG_EDGE  = 1'b0;

    localparam int DEF_NUM_IRQ       = 8;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_FILTER_CYCLES = 2;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/int_req_filter.sv
// ============================================================================
// Module      : int_req_filter
// Description : Single-channel pin synchroniser and glitch filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_req_filter
    import int_req_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic init_clear,
    input  logic pin_i,
    output logic filtered_level_o,
    output logic low_set_o
);

    logic sync_out;

    generate
        if (SYNC_STAGES == 0) begin : g_sync_bypass
            assign sync_out = pin_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Resetting to 1 means a pin held high through reset looks idle, not a rising edge.
            always_ff @(negedge clock or posedge reset) begin
                if (reset) begin
                    sync_q <= '1;
                end else if (init_clear) begin
                    sync_q <= '1;
                end else begin
                    sync_q <= (sync_q << 1) | SYNC_STAGES'(pin_i);
                end
            end

            assign sync_out = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    generate
        if (FILTER_CYCLES == 0) begin : g_filt_bypass
            assign filtered_level_o = sync_out;
        end else begin : g_filt
            localparam int CNT_W = (clog2(FILTER_CYCLES + 1) < 1) ? 1 : clog2(FILTER_CYCLES + 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             filt_q;
            logic             filt_d;

            always_comb begin
                cnt_d  = '0;
                filt_d = filt_q;
                if (sync_out != filt_q) begin
                    if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
                        filt_d = sync_out;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(negedge clock or posedge reset) begin
                if (reset) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b1;
                end else if (init_clear) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b1;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign filtered_level_o = filt_q;
        end
    endgenerate

    assign low_set_o = ~filtered_level_o;

endmodule

`default_nettype wire

// File: rtl/int_req_array.sv
// ============================================================================
// Module      : int_req_array
// Description : Parametrised interrupt request register with per-channel mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_req_array
    import int_req_pkg::*;
#(
    parameter int NUM_IRQ       = DEF_NUM_IRQ,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               init_clear,
    input  logic [NUM_IRQ-1:0] trigger_mode,
    input  logic               freeze,
    input  logic [NUM_IRQ-1:0] clear_interrupt_request,
    input  logic [NUM_IRQ-1:0] set_interrupt_request,
    input  logic [NUM_IRQ-1:0] interrupt_request_pin,
    output logic [NUM_IRQ-1:0] interrupt_request_register,
    output logic [NUM_IRQ-1:0] edge_overrun,
    output logic [NUM_IRQ-1:0] filtered_level
);

    logic [NUM_IRQ-1:0] filt;
    logic [NUM_IRQ-1:0] low_set;
    logic [NUM_IRQ-1:0] edge_evt;
    logic [NUM_IRQ-1:0] latch_q;
    logic [NUM_IRQ-1:0] latch_d;
    logic [NUM_IRQ-1:0] irr_q;
    logic [NUM_IRQ-1:0] irr_d;
    logic [NUM_IRQ-1:0] ovr_q;
    logic [NUM_IRQ-1:0] ovr_d;

    generate
        for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
            int_req_filter #(
                .SYNC_STAGES   (SYNC_STAGES),
                .FILTER_CYCLES (FILTER_CYCLES)
            ) u_filter (
                .clock            (clock),
                .reset            (reset),
                .init_clear       (init_clear),
                .pin_i            (interrupt_request_pin[i]),
                .filtered_level_o (filt[i]),
                .low_set_o        (low_set[i])
            );
        end
    endgenerate

    assign edge_evt = latch_q & filt;

    always_comb begin
        latch_d = latch_q;
        irr_d   = irr_q;
        ovr_d   = ovr_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            // The latch stays armed during freeze so the edge is taken once freeze drops.
            if (clear_interrupt_request[i]) begin
                latch_d[i] = 1'b0;
            end else if (low_set[i]) begin
                latch_d[i] = 1'b1;
            end else if (edge_evt[i] && !freeze) begin
                latch_d[i] = 1'b0;
            end

            if (clear_interrupt_request[i]) begin
                irr_d[i] = 1'b0;
            end else if (set_interrupt_request[i]) begin
                irr_d[i] = 1'b1;
            end else if (freeze) begin
                irr_d[i] = irr_q[i];
            end else if (trigger_mode[i] == TRIG_LEVEL) begin
                irr_d[i] = filt[i];
            end else begin
                irr_d[i] = irr_q[i] | edge_evt[i];
            end

            if (clear_interrupt_request[i]) begin
                ovr_d[i] = 1'b0;
            end else if ((trigger_mode[i] == TRIG_EDGE) && edge_evt[i] && !freeze && irr_q[i]) begin
                ovr_d[i] = 1'b1;
            end
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            latch_q <= '0;
            irr_q   <= '0;
            ovr_q   <= '0;
        end else if (init_clear) begin
            latch_q <= '0;
            irr_q   <= '0;
            ovr_q   <= '0;
        end else begin
            latch_q <= latch_d;
            irr_q   <= irr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign interrupt_request_register = irr_q;
    assign edge_overrun               = ovr_q;
    assign filtered_level             = filt;

endmodule

`default_nettype wire

// File: tb/tb_int_req_array.sv
// ============================================================================
// Module      : tb_int_req_array
// Description : Scoreboard testbench for int_req_array with default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_int_req_array;

    logic       clock = 1'b1;
    logic       reset = 1'b0;
    logic       init_clear = 1'b0;
    logic [7:0] trig = 8'h00;
    logic       frz = 1'b0;
    logic [7:0] clr = 8'h00;
    logic [7:0] setr = 8'h00;
    logic [7:0] pin = 8'h00;
    logic [7:0] irr;
    logic [7:0] ovr;
    logic [7:0] filt;

    int edges = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int         at;
        int         sel;
        logic [7:0] mask;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] obs;

    always #5 clock = ~clock;

    int_req_array dut (
        .clock                      (clock),
        .reset                      (reset),
        .init_clear                 (init_clear),
        .trigger_mode               (trig),
        .freeze                     (frz),
        .clear_interrupt_request    (clr),
        .set_interrupt_request      (setr),
        .interrupt_request_pin      (pin),
        .interrupt_request_register (irr),
        .edge_overrun               (ovr),
        .filtered_level             (filt)
    );

    task automatic push(input int at, input int sel, input logic [7:0] mask,
                        input logic [7:0] val, input string name);
        exp_t e;
        e.at = at; e.sel = sel; e.mask = mask; e.val = val; e.name = name;
        sbq.push_back(e);
    endtask

    function automatic logic [7:0] pick(input int sel);
        case (sel)
            0:       return irr;
            1:       return ovr;
            default: return filt;
        endcase
    endfunction

    task automatic tick();
        @(negedge clock);
        edges++;
        @(posedge clock);
    endtask

    task automatic test_reset();
        int e0;
        #1 reset = 1'b1;
        #1;
        push(edges, 2, 8'hFF, 8'hFF, "rst_filt");
        push(edges, 0, 8'hFF, 8'h00, "rst_irr");
        push(edges, 1, 8'hFF, 8'h00, "rst_ovr");
        for (int j = sbq.size() - 1; j >= 0; j--) begin
            if (sbq[j].at == edges) begin
                obs = pick(sbq[j].sel) & sbq[j].mask;
                n_total++;
                if (obs !== sbq[j].val) $display("FAIL %s: observed %h expected %h", sbq[j].name, obs, sbq[j].val);
                else n_pass++;
                sbq.delete(j);
            end
        end
        @(posedge clock);
        reset = 1'b0;
        e0 = edges;
        push(e0 + 3, 2, 8'hFF, 8'hFF, "filt_hold");
        push(e0 + 4, 2, 8'hFF, 8'h00, "filt_fall");
        push(e0 + 8, 0, 8'hFF, 8'h00, "irr_idle");
        for (int c = 0; c < 8; c++) begin
            tick();
            for (int j = sbq.size() - 1; j >= 0; j--) begin
                if (sbq[j].at == edges) begin
                    obs = pick(sbq[j].sel) & sbq[j].mask;
                    n_total++;
                    if (obs !== sbq[j].val) $display("FAIL %s: observed %h expected %h", sbq[j].name, obs, sbq[j].val);
                    else n_pass++;
                    sbq.delete(j);
                end
            end
        end
    endtask

    task automatic test_edge_capture();
        int e0;
        e0 = edges;
        for (int c = 0; c < 16; c++) begin
            if (c == 0) begin
                pin[3] = 1'b1;
                push(e0 + 4, 0, 8'hFF, 8'h00, "edge_pre");
                push(e0 + 5, 0, 8'hFF, 8'h08, "edge_cap");
            end
            if (c == 5) begin
                pin[3] = 1'b0;
                push(e0 + 13, 0, 8'hFF, 8'h08, "edge_sticky");
                push(e0 + 13, 1, 8'hFF, 8'h00, "edge_no_ovr");
            end
            if (c == 13) begin
                clr[3] = 1'b1;
                push(e0 + 14, 0, 8'hFF, 8'h00, "edge_clr");
            end
            if (c == 14) clr = 8'h00;
            tick();
            for (int j = sbq.size() - 1; j >= 0; j--) begin
                if (sbq[j].at == edges) begin
                    obs = pick(sbq[j].sel) & sbq[j].mask;
                    n_total++;
                    if (obs !== sbq[j].val) $display("FAIL %s: observed %h expected %h", sbq[j].name, obs, sbq[j].val);
                    else n_pass++;
                    sbq.delete(j);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int e0;
        e0 = edges;
        for (int c = 0; c < 18; c++) begin
            if (c == 0) begin
                pin[5] = 1'b1;
                push(e0 + 3, 2, 8'h20, 8'h00, "glitch_filt_a");
                push(e0 + 4, 2, 8'h20, 8'h00, "glitch_filt_b");
                push(e0 + 6, 0, 8'hFF, 8'h00, "glitch_irr");
            end
            if (c == 1) pin[5] = 1'b0;
            if (c == 8) begin
                pin[5] = 1'b1;
                push(e0 + 12, 2, 8'h20, 8'h20, "pulse2_filt");
                push(e0 + 12, 0, 8'hFF, 8'h00, "pulse2_pre");
                push(e0 + 13, 0, 8'hFF, 8'h20, "pulse2_irr");
            end
            if (c == 10) pin[5] = 1'b0;
            if (c == 16) begin
                clr[5] = 1'b1;
                push(e0 + 17, 0, 8'hFF, 8'h00, "pulse2_clr");
            end
            if (c == 17) clr = 8'h00;
            tick();
            for (int j = sbq.size() - 1; j >= 0; j--) begin
                if (sbq[j].at == edges) begin
                    obs = pick(sbq[j].sel) & sbq[j].mask;
                    n_total++;
                    if (obs !== sbq[j].val) $display("FAIL %s: observed %h expected %h", sbq[j].name, obs, sbq[j].val);
                    else n_pass++;
                    sbq.delete(j);
                end
            end
        end
    endtask

    task automatic test_level();
        int e0;
        e0 = edges;
        for (int c = 0; c < 16; c++) begin
            if (c == 0) begin
                trig[0] = 1'b1;
                pin[0]  = 1'b1;
                push(e0 + 4, 0, 8'h01, 8'h00, "level_pre");
                push(e0 + 5, 0, 8'h01, 8'h01, "level_rise");
            end
            if (c == 8) begin
                pin[0] = 1'b0;
                push(e0 + 12, 0, 8'h01, 8'h01, "level_hold");
                push(e0 + 13, 0, 8'h01, 8'h00, "level_fall");
            end
            if (c == 14) trig[0] = 1'b0;
            tick();
            for (int j = sbq.size() - 1; j >= 0; j--) begin
                if (sbq[j].at == edges) begin
                    obs = pick(sbq[j].sel) & sbq[j].mask;
                    n_total++;
                    if (obs !== sbq[j].val) $display("FAIL %s: observed %h expected %h", sbq[j].name, obs, sbq[j].val);
                    else n_pass++;
                    sbq.delete(j);
                end
            end
        end
    endtask

    task automatic test_freeze();
        int e0;
        e0 = edges;
        for (int c = 0; c < 18; c++) begin
            if (c == 0) begin
                frz    = 1'b1;
                pin[2] = 1'b1;
                push(e0 + 8, 0, 8'hFF, 8'h00, "freeze_hold");
                push(e0 + 8, 1, 8'hFF, 8'h00, "freeze_ovr");
            end
            if (c == 8) begin
                frz = 1'b0;
                push(e0 + 9, 0, 8'hFF, 8'h04, "freeze_release");
            end
            if (c == 10) pin[2] = 1'b0;
            if (c == 16) begin
                clr[2] = 1'b1;
                push(e0 + 17, 0, 8'hFF, 8'h00, "freeze_clr");
            end
            if (c == 17) clr = 8'h00;
            tick();
            for (int j = sbq.size() - 1; j >= 0; j--) begin
                if (sbq[j].at == edges) begin
                    obs = pick(sbq[j].sel) & sbq[j].mask;
                    n_total++;
                    if (obs !== sbq[j].val) $display("FAIL %s: observed %h expected %h", sbq[j].name, obs, sbq[j].val);
                    else n_pass++;
                    sbq.delete(j);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int e0;
        e0 = edges;
        for (int c = 0; c < 30; c++) begin
            if (c == 0) begin
                pin[7] = 1'b1;
                push(e0 + 5, 0, 8'hFF, 8'h80, "ovr_first");
            end
            if (c == 6) pin[7] = 1'b0;
            if (c == 12) begin
                pin[7] = 1'b1;
                push(e0 + 16, 1, 8'hFF, 8'h00, "ovr_pre");
                push(e0 + 17, 1, 8'hFF, 8'h80, "ovr_set");
                push(e0 + 17, 0, 8'hFF, 8'h80, "ovr_irr");
            end
            if (c == 18) begin
                clr[7] = 1'b1;
                push(e0 + 19, 0, 8'hFF, 8'h00, "ovr_clr_irr");
                push(e0 + 19, 1, 8'hFF, 8'h00, "ovr_clr_ovr");
            end
            if (c == 19) begin
                clr = 8'h00;
                push(e0 + 24, 0, 8'hFF, 8'h00, "ovr_no_recap");
            end
            if (c == 24) pin[7] = 1'b0;
            tick();
            for (int j = sbq.size() - 1; j >= 0; j--) begin
                if (sbq[j].at == edges) begin
                    obs = pick(sbq[j].sel) & sbq[j].mask;
                    n_total++;
                    if (obs !== sbq[j].val) $display("FAIL %s: observed %h expected %h", sbq[j].name, obs, sbq[j].val);
                    else n_pass++;
                    sbq.delete(j);
                end
            end
        end
    endtask

    task automatic test_priority_reset();
        int e0;
        e0 = edges;
        for (int c = 0; c < 17; c++) begin
            if (c == 0) begin
                setr[1] = 1'b1;
                clr[1]  = 1'b1;
                push(e0 + 1, 0, 8'hFF, 8'h00, "prio_clr_wins");
            end
            if (c == 1) begin
                clr = 8'h00;
                push(e0 + 2, 0, 8'hFF, 8'h02, "prio_sw_set");
            end
            if (c == 2) begin
                setr = 8'h40;
                clr  = 8'h02;
                push(e0 + 3, 0, 8'hFF, 8'h40, "prio_mixed");
            end
            if (c == 3) begin
                setr       = 8'h00;
                clr        = 8'h00;
                init_clear = 1'b1;
                push(e0 + 4, 0, 8'hFF, 8'h00, "init_irr");
                push(e0 + 4, 2, 8'hFF, 8'hFF, "init_filt");
            end
            if (c == 4) begin
                init_clear = 1'b0;
                pin[4]     = 1'b1;
                setr[6]    = 1'b1;
                push(e0 + 7, 0, 8'hFF, 8'h40, "pre_async");
            end
            if (c == 5) setr = 8'h00;
            if (c == 7) begin
                reset = 1'b1;
                #1;
                n_total++;
                if (irr !== 8'h00) $display("FAIL async_irr: observed %h expected %h", irr, 8'h00);
                else n_pass++;
                n_total++;
                if (ovr !== 8'h00) $display("FAIL async_ovr: observed %h expected %h", ovr, 8'h00);
                else n_pass++;
                n_total++;
                if (filt !== 8'hFF) $display("FAIL async_filt: observed %h expected %h", filt, 8'hFF);
                else n_pass++;
            end
            if (c == 8) begin
                reset = 1'b0;
                push(e0 + 16, 0, 8'hFF, 8'h00, "high_through_reset");
                push(e0 + 16, 2, 8'hFF, 8'h10, "post_reset_filt");
            end
            tick();
            for (int j = sbq.size() - 1; j >= 0; j--) begin
                if (sbq[j].at == edges) begin
                    obs = pick(sbq[j].sel) & sbq[j].mask;
                    n_total++;
                    if (obs !== sbq[j].val) $display("FAIL %s: observed %h expected %h", sbq[j].name, obs, sbq[j].val);
                    else n_pass++;
                    sbq.delete(j);
                end
            end
        end
        pin = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_edge_capture();
        test_glitch();
        test_level();
        test_freeze();
        test_overrun();
        test_priority_reset();
        while (sbq.size() > 0) begin
            n_total++;
            $display("FAIL %s: observed unreached expected cycle %0d", sbq[0].name, sbq[0].at);
            void'(sbq.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/int_req_array.md
Name: int_req_array

Overview:
- Parametrised successor of the 8259 interrupt request register. Accepts NUM_IRQ request pins, with a per-channel edge/level mode instead of one global mode.
- New per channel: input synchroniser, glitch filter, software set, and a sticky edge-overrun flag.
- Sits between the IR pins and the priority resolver. The resolver consumes interrupt_request_register and drives freeze/clear.

Parameters:
NUM_IRQ, 8, number of request channels (1..32)
SYNC_STAGES, 2, synchroniser flops per pin (0 = bypass)
FILTER_CYCLES, 2, consecutive differing samples required before the filtered level changes (0 = bypass)

Ports:
clock  input  1  system clock; all state updates on the falling edge
reset  input  1  asynchronous, active-high reset
init_clear  input  1  synchronous clear (ICW1 write)
trigger_mode  input  NUM_IRQ  per channel: 1 = level, 0 = edge
freeze  input  1  hold IRR during INTA sequence
clear_interrupt_request  input  NUM_IRQ  per-channel clear, one-hot or multi-hot
set_interrupt_request  input  NUM_IRQ  software request set
interrupt_request_pin  input  NUM_IRQ  raw IR pins
interrupt_request_register  output  NUM_IRQ  IRR
edge_overrun  output  NUM_IRQ  sticky: edge arrived while IRR bit already set
filtered_level  output  NUM_IRQ  debug view of the filtered pin level

Behaviour:
- Edge and reset: all flops update on the negedge of clock. reset is asynchronous and active-high.
- Reset values:
  - sync flops = 1, filtered_level = 1, filter counters = 0
  - low-input latch = 0
  - interrupt_request_register = 0, edge_overrun = 0
- init_clear: same values as reset, applied synchronously.
- Synchroniser: SYNC_STAGES-deep shift of the pin. sync_out is the last stage.
- Filter:
  - Counter (width clog2(FILTER_CYCLES+1)) increments each edge while sync_out != filtered_level.
  - On the edge where the count would reach FILTER_CYCLES, filtered_level takes sync_out and the counter returns to 0.
  - Whenever sync_out == filtered_level, the counter returns to 0.
  - FILTER_CYCLES = 1: filtered_level follows sync_out one edge late. FILTER_CYCLES = 0: combinational pass-through.
- Low-input latch (edge mode):
  - Set when filtered_level == 0.
  - Cleared on clear_interrupt_request[i], and on an edge event captured while freeze == 0.
  - Otherwise holds.
- Edge event: edge_evt[i] = latch[i] & filtered_level[i].
- IRR next state per bit, first match wins:
  - clear → 0
  - set → 1
  - freeze → hold
  - trigger_mode = 1 (level) → filtered_level
  - else → IRR | edge_evt (sticky until cleared)
- Freeze: an edge event during freeze is not lost. The latch stays armed and the event is captured on the first edge after freeze drops, provided the pin is still high.
- edge_overrun[i]:
  - Set when edge mode, edge_evt, freeze = 0, IRR[i] = 1 and clear[i] = 0.
  - Cleared by clear[i] or init_clear.
  - clear wins if both occur on the same edge.
- Simultaneous clear and set on the same bit: clear wins.
- Mode change mid-operation: takes effect on the next edge. A level→edge change keeps the current IRR value.
- Latency: pin change sampled at edge k reaches IRR after edge k + SYNC_STAGES + FILTER_CYCLES. With defaults, IRR is visible after the 5th falling edge counting edge k.
- Pin high through reset never produces an edge request.

Decomposition:
- Shared package int_req_pkg:
  - constants TRIG_LEVEL = 1'b1, TRIG_EDGE = 1'b0
  - clog2 helper function
  - default parameter constants
- One sub-module, int_req_filter: single-channel synchroniser + glitch filter with outputs filtered_level and low-latch set.
  - Generate-instantiated NUM_IRQ times. IRR/overrun logic stays in the top.

Test Plan:
- Edge capture, channel 3 in edge mode, defaults: pin3 low 6 edges then high → IRR = 8'h08 exactly 5 falling edges after the first high sample. IRR stays 8'h08 after the pin drops, until clear[3].
- Glitch rejection, FILTER_CYCLES = 2: pin5 low for 6 edges, then a 1-edge high pulse → IRR stays 0, filtered_level[5] stays 0. A 2-edge high pulse → IRR[5] = 1.
- Level mode, channel 0: pin0 high → IRR[0] = 1. Pin0 low → IRR[0] = 0 after the same latency, with no clear needed.
- Freeze, channel 2 in edge mode: edge during freeze holds IRR = 0. After freeze drops with the pin still high, IRR[2] = 1 on the next edge.
- Overrun, channel 7 in edge mode: IRR[7] = 1, pin toggles low then high → edge_overrun = 8'h80. clear[7] → IRR[7] = 0, edge_overrun = 0.
- Priority and reset: same-edge set[1] + clear[1] → IRR[1] = 0. Async reset asserted mid-filter → all outputs 0 and filtered_level = all ones immediately, with no clock edge.
